// File: rtl/bch_arb_pkg.sv
// bch_arb_pkg: shared state enum and width helpers for the BCH encoder arbiter
package bch_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DRAIN} arb_state_e;
  function automatic int data_words(input int data_bits, input int bits);
    return (data_bits + bits - 1) / bits;
  endfunction
  function automatic int id_width(input int nreq);
    return $clog2(nreq) > 1 ? $clog2(nreq) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin one-hot selector starting at i_ptr
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant
);
  logic [NREQ-1:0] w_rot;
  logic [NREQ-1:0] w_low;
  assign w_rot = NREQ'({i_req, i_req} >> i_ptr);
  assign w_low = w_rot & (~w_rot + 1'b1);
  assign o_grant = NREQ'({w_low, w_low} >> (NREQ - int'(i_ptr)));
endmodule

// File: rtl/bch_encode_arbiter.sv
// bch_encode_arbiter: round-robin sharing of one bch_encode between NREQ frame sources
module bch_encode_arbiter
  import bch_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DATA_BITS = 5,
  parameter int BITS = 1,
  localparam int DATA_WORDS = data_words(DATA_BITS, BITS),
  localparam int IDW = id_width(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*BITS-1:0] req_data,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      take,
  output logic                 enc_start,
  output logic                 enc_ce,
  output logic [BITS-1:0]      enc_data_in,
  input  logic                 enc_ready,
  input  logic                 enc_first,
  input  logic                 enc_last,
  input  logic                 enc_data_bits,
  input  logic                 enc_ecc_bits,
  input  logic [BITS-1:0]      enc_data_out,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic                 out_first,
  output logic                 out_last,
  output logic                 out_ecc,
  output logic [BITS-1:0]      out_data,
  output logic [IDW-1:0]       out_id
);
  localparam int CW = $clog2(DATA_WORDS + 1);
  arb_state_e      r_state, w_state_next;
  logic [NREQ-1:0] r_grant, w_pick;
  logic [IDW-1:0]  r_ptr, w_gidx;
  logic [CW-1:0]   r_wcnt;
  logic [BITS-1:0] w_gdata;
  logic            w_take_en, w_act, w_feed;
  rr_pick #(.NREQ(NREQ), .PW(IDW)) u_pick (.i_req(req), .i_ptr(r_ptr), .o_grant(w_pick));
  // encode the owner index and mux its current word
  always_comb begin
    w_gidx = '0;
    w_gdata = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (r_grant[k]) w_gidx = IDW'(k);
      w_gdata = w_gdata | (req_data[k*BITS +: BITS] & {BITS{r_grant[k]}});
    end
  end
  // next state and encoder handshake; START ignores out_ready so the frame always launches
  always_comb begin
    w_state_next = r_state;
    enc_start = 1'b0;
    enc_ce = 1'b0;
    w_take_en = 1'b0;
    case (r_state)
      S_IDLE: w_state_next = (enc_ready && |req) ? S_START : S_IDLE;
      S_START: begin
        enc_start = 1'b1;
        enc_ce = 1'b1;
        w_take_en = 1'b1;
        w_state_next = DATA_WORDS == 1 ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        enc_ce = out_ready;
        w_take_en = out_ready;
        w_state_next = (out_ready && r_wcnt == CW'(DATA_WORDS - 1)) ? S_DRAIN : S_RUN;
      end
      S_DRAIN: begin
        enc_ce = out_ready;
        w_state_next = (out_ready && enc_last) ? S_IDLE : S_DRAIN;
      end
      default: w_state_next = S_IDLE;
    endcase
  end
  assign w_act = r_state != S_IDLE;
  assign w_feed = r_state == S_START || r_state == S_RUN;
  assign grant = r_grant;
  assign take = w_take_en ? r_grant : '0;
  assign enc_data_in = w_feed ? w_gdata : '0;
  assign out_valid = enc_ce & w_act & (enc_data_bits | enc_ecc_bits);
  assign out_data = w_act ? enc_data_out : '0;
  assign out_first = w_act & enc_first;
  assign out_last = w_act & enc_last;
  assign out_ecc = w_act & enc_ecc_bits;
  assign out_id = w_gidx;
  // state, ownership, word count and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ptr <= '0;
      r_wcnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && w_state_next == S_START) begin
        r_grant <= w_pick;
        r_wcnt <= '0;
      end
      if (r_state == S_START) r_wcnt <= CW'(1);
      else if (r_state == S_RUN && out_ready) r_wcnt <= r_wcnt + 1'b1;
      if (r_state == S_DRAIN && w_state_next == S_IDLE) begin
        r_grant <= '0;
        r_ptr <= (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bch_encode_arbiter.sv
// tb_bch_encode_arbiter: scoreboard bench with behavioral BCH(15,5) encoder and requesters
module tb_bch_encode_arbiter;
  localparam int NREQ = 4;
  localparam int DB = 5;
  localparam int BITS = 1;
  typedef struct packed {logic [1:0] id; logic d; logic f; logic l; logic e;} word_t;
  logic clk = 0;
  logic reset = 1;
  logic [NREQ-1:0] req, grant, take;
  logic [NREQ*BITS-1:0] req_data;
  logic enc_start, enc_ce, enc_ready;
  logic [BITS-1:0] enc_data_in;
  logic enc_first = 0, enc_last = 0, enc_data_bits = 0, enc_ecc_bits = 0;
  logic [BITS-1:0] enc_data_out = '0;
  logic out_ready = 1;
  logic out_valid, out_first, out_last, out_ecc;
  logic [BITS-1:0] out_data;
  logic [1:0] out_id;
  int total = 0, bad = 0;
  word_t sb[$];
  word_t m_exp, m_got;
  logic [3:0] glog[$];
  logic [4:0] frames[NREQ][8];
  int fcnt[NREQ], fidx[NREQ], widx[NREQ], ntake[NREQ];
  logic rdy_en = 1, e_flush = 1;
  logic [1:0] e_ph = 0;
  int e_cnt = 0;
  logic [9:0] e_lf = 0;

  bch_encode_arbiter #(.NREQ(NREQ), .DATA_BITS(DB), .BITS(BITS)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .grant(grant), .take(take),
    .enc_start(enc_start), .enc_ce(enc_ce), .enc_data_in(enc_data_in),
    .enc_ready(enc_ready), .enc_first(enc_first), .enc_last(enc_last),
    .enc_data_bits(enc_data_bits), .enc_ecc_bits(enc_ecc_bits), .enc_data_out(enc_data_out),
    .out_ready(out_ready), .out_valid(out_valid), .out_first(out_first), .out_last(out_last),
    .out_ecc(out_ecc), .out_data(out_data), .out_id(out_id)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] lstep(input logic [9:0] s, input logic b);
    logic fb = b ^ s[9];
    return {s[8:0], 1'b0} ^ (fb ? 10'h137 : 10'h000);
  endfunction

  function automatic logic [9:0] rem(input logic [4:0] m);
    logic [14:0] p = {m, 10'b0};
    for (int i = 14; i >= 10; i--) if (p[i]) p = p ^ (15'h0537 << (i - 10));
    return p[9:0];
  endfunction

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      req[k] = fidx[k] < fcnt[k];
      req_data[k] = frames[k][fidx[k] % 8][4 - widx[k]];
    end
  end

  always @(posedge clk)
    for (int k = 0; k < NREQ; k++)
      if (reset) begin
        widx[k] <= 0;
        fidx[k] <= fcnt[k];
      end else if (take[k]) begin
        if (widx[k] == DB - 1) begin
          widx[k] <= 0;
          fidx[k] <= fidx[k] + 1;
        end else widx[k] <= widx[k] + 1;
      end

  assign enc_ready = (e_ph == 0) && rdy_en;

  always @(posedge clk)
    if (e_flush) begin
      e_ph <= 0; e_cnt <= 0; enc_data_bits <= 0; enc_ecc_bits <= 0;
      enc_first <= 0; enc_last <= 0; enc_data_out <= '0;
    end else if (enc_ce) begin
      if (enc_start) begin
        e_lf <= lstep(10'd0, enc_data_in[0]); e_cnt <= 1; e_ph <= 1;
        enc_data_out <= enc_data_in; enc_data_bits <= 1; enc_ecc_bits <= 0; enc_first <= 1; enc_last <= 0;
      end else if (e_ph == 1 && e_cnt < DB) begin
        e_lf <= lstep(e_lf, enc_data_in[0]); e_cnt <= e_cnt + 1;
        enc_data_out <= enc_data_in; enc_data_bits <= 1; enc_first <= 0;
      end else if (e_ph == 1) begin
        enc_data_out <= e_lf[9 - (e_cnt - DB)]; enc_data_bits <= 0; enc_ecc_bits <= 1;
        enc_first <= 0; enc_last <= (e_cnt == DB + 9); e_cnt <= e_cnt + 1;
        if (e_cnt == DB + 9) e_ph <= 2;
      end else begin
        e_ph <= 0; enc_data_bits <= 0; enc_ecc_bits <= 0; enc_first <= 0; enc_last <= 0; enc_data_out <= '0;
      end
    end

  always @(negedge clk) begin
    #2;
    for (int k = 0; k < NREQ; k++) if (take[k]) ntake[k]++;
    if (enc_start) glog.push_back(grant);
    if (out_valid && out_ready) begin
      m_got = {out_id, out_data[0], out_first, out_last, out_ecc};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_extra got=%b exp=none", m_got);
      end else begin
        m_exp = sb.pop_front();
        if (m_got !== m_exp) begin
          bad++;
          $display("FAIL sb_word got=%b exp=%b", m_got, m_exp);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, a, e);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input int r, input logic [4:0] m);
    logic [9:0] p = rem(m);
    frames[r][fcnt[r] % 8] = m;
    fcnt[r]++;
    for (int k = 0; k < DB; k++) sb.push_back({2'(r), m[4 - k], k == 0, 1'b0, 1'b0});
    for (int j = 0; j < 10; j++) sb.push_back({2'(r), p[9 - j], 1'b0, j == 9, 1'b1});
  endtask

  task automatic wait_start(input int lim);
    int n = 0;
    do begin tick(); n++; end while (!enc_start && n < lim);
    chk("start_seen", {31'd0, enc_start}, 32'd1);
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    do begin tick(); n++; end while ((sb.size() != 0 || grant != 0) && n < lim);
    chk("frames_done", sb.size() + (grant != 0 ? 100 : 0), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int t0;
    repeat (3) tick();
    chk("rst_grant", grant, 0);
    chk("rst_take", take, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_start", enc_start, 0);
    chk("rst_ce", enc_ce, 0);
    chk("rst_id", out_id, 0);
    reset = 0;
    e_flush = 0;
    t0 = ntake[0];
    issue(0, 5'b10110);
    wait_start(20);
    chk("t1_grant", grant, 4'b0001);
    chk("t1_take_start", take, 4'b0001);
    chk("t1_id", out_id, 0);
    wait_done(100);
    chk("t1_ntake", ntake[0] - t0, 5);
    reset = 1;
    tick();
    chk("rst2_grant", grant, 0);
    reset = 0;
    glog.delete();
    issue(0, 5'b00001);
    issue(1, 5'b11111);
    issue(2, 5'b01010);
    issue(3, 5'b10011);
    issue(0, 5'b01101);
    wait_done(400);
    chk("rr_count", glog.size(), 5);
    chk("rr_g0", glog[0], 4'b0001);
    chk("rr_g1", glog[1], 4'b0010);
    chk("rr_g2", glog[2], 4'b0100);
    chk("rr_g3", glog[3], 4'b1000);
    chk("rr_g4", glog[4], 4'b0001);
    glog.delete();
    issue(2, 5'b11000);
    wait_start(20);
    issue(0, 5'b00111);
    issue(2, 5'b10101);
    wait_done(300);
    chk("fair_count", glog.size(), 3);
    chk("fair_g0", glog[0], 4'b0100);
    chk("fair_g1", glog[1], 4'b0001);
    chk("fair_g2", glog[2], 4'b0100);
    issue(1, 5'b01001);
    wait_start(20);
    tick();
    chk("bp_take1", take, 4'b0010);
    tick();
    out_ready = 0;
    #1;
    chk("bp_take0a", take, 0);
    chk("bp_ce0a", enc_ce, 0);
    chk("bp_valid0a", out_valid, 0);
    tick();
    chk("bp_take0b", take, 0);
    chk("bp_ce0b", enc_ce, 0);
    tick();
    out_ready = 1;
    #1;
    chk("bp_take_resume", take, 4'b0010);
    chk("bp_ce_resume", enc_ce, 1);
    wait_done(100);
    issue(3, 5'b11010);
    wait_start(20);
    tick();
    tick();
    rdy_en = 0;
    reset = 1;
    tick();
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_take", take, 0);
    chk("mid_rst_ce", enc_ce, 0);
    reset = 0;
    sb.delete();
    issue(1, 5'b10001);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("nordy_grant", grant, 0);
      chk("nordy_valid", out_valid, 0);
    end
    e_flush = 1;
    tick();
    e_flush = 0;
    chk("flush_grant", grant, 0);
    rdy_en = 1;
    tick();
    chk("rdy_grant", grant, 4'b0010);
    chk("rdy_start", enc_start, 1);
    wait_done(100);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bch_encode_arbiter.md
# bch_encode_arbiter

Round-robin scheduler that shares one `bch_encode` instance between NREQ independent frame sources. It grants the encoder to one requester for a whole codeword, then drives `start`/`ce`/`data_in` for that frame. It forwards the encoder's output stream tagged with the owning requester's index, and applies downstream backpressure by gating the encoder clock enable. It sits between the per-channel data sources and the encoder, alongside the encoder's pipeline/BUFG benchmark wrapper.

## Interface
- `NREQ`, 4, number of requesters (2..16)
- `DATA_BITS`, 5, message bits per codeword, identical to the encoder's setting
- `BITS`, 1, bits per encoder cycle
- `DATA_WORDS`, derived localparam, `(DATA_BITS+BITS-1)/BITS`, encoder input cycles per frame
- `clk`  in  1  single clock
- `reset`  in  1  synchronous, active-high
- `req`  in  NREQ  requester i has a complete frame pending; held until its frame has been fully taken
- `req_data`  in  NREQ*BITS  requester i's current word at bits `[i*BITS +: BITS]`
- `grant`  out  NREQ  one-hot owner of the encoder, or zero
- `take`  out  NREQ  requester i's current word is consumed this cycle; advance to the next word
- `enc_start`, `enc_ce`  out  1 each  to encoder `start` / `ce`
- `enc_data_in`  out  BITS  to encoder `data_in`
- `enc_ready`, `enc_first`, `enc_last`, `enc_data_bits`, `enc_ecc_bits`  in  1 each  from the encoder
- `enc_data_out`  in  BITS  from the encoder
- `out_ready`  in  1  downstream accepts a word
- `out_valid`, `out_first`, `out_last`, `out_ecc`  out  1 each  output word qualifiers; `out_ecc` = word is parity
- `out_data`  out  BITS  codeword word
- `out_id`  out  clog2(NREQ), min 1  index of the requester owning `out_data`

## Operation
- Registers:
  - state ∈ {IDLE, START, RUN, DRAIN}
  - one-hot `grant`
  - round-robin pointer `ptr`, the highest-priority index
  - word counter `wcnt` (clog2(DATA_WORDS+1) bits)
- IDLE:
  - If `enc_ready`=1 and `req`≠0, select the first set `req` bit scanning from `ptr` upward, with wrap-around.
  - Register it in `grant`, clear `wcnt`, go to START.
  - If `enc_ready`=0, nothing is granted even if requests are pending.
- START: lasts exactly one cycle and does not depend on `out_ready`.
  - `enc_start`=1, `enc_ce`=1, `take[g]`=1, `wcnt`←1.
  - Go to RUN, or to DRAIN if DATA_WORDS=1.
- RUN:
  - `enc_ce`=`out_ready`.
  - `take[g]`=`out_ready`; `wcnt` increments on `take`.
  - When `take` fires with `wcnt`=DATA_WORDS-1, go to DRAIN.
- DRAIN: covers the ECC cycles and pipeline flush.
  - `enc_ce`=`out_ready`, `take`=0, `enc_data_in`=0.
  - On `enc_last`=1 with `enc_ce`=1: set `ptr`←g+1 (mod NREQ), clear `grant`, go to IDLE.
- `enc_data_in`=`req_data[g]` in START and RUN, otherwise 0.
- Output forwarding:
  - `out_valid`=`enc_ce` & (state≠IDLE) & (`enc_data_bits` | `enc_ecc_bits`).
  - `out_data`=`enc_data_out`, `out_first`=`enc_first`, `out_last`=`enc_last`, `out_ecc`=`enc_ecc_bits`.
  - `out_id`=encoded `grant`. It is stable for the whole frame because only one frame is in flight.
- A requester that drops `req` mid-frame is ignored; the frame completes with whatever `req_data` presents.
- `req` from non-owners has no effect until IDLE.
- Reset:
  - All state clears: state=IDLE, `grant`=0, `ptr`=0, `wcnt`=0.
  - All outputs 0 the cycle after `reset` is sampled high.
  - Reset mid-frame abandons the frame. The encoder is not reset; the arbiter waits in IDLE for `enc_ready`=1 and suppresses `out_valid`, so residual encoder output is discarded.

## Timing
- All outputs are combinational from registered state plus the `out_ready`/`enc_*` inputs. No combinational path exists from `req` to `take`.
- Cycle 0 (IDLE with `req`, `enc_ready`): `grant` registered. Cycle 1: `enc_start`, first `take`.
- Minimum frame occupancy is DATA_WORDS + ECC cycles + encoder pipeline latency, plus one IDLE cycle between frames.
- `out_ready`=0 freezes the encoder, `wcnt`, `take` and the output word, except in the START cycle.

## Structure
- Package `bch_arb_pkg`: state enum and the `DATA_WORDS`/id-width helper functions. The BCH parameter derivation stays in the shared `bch_params` include.
- One sub-module, `rr_pick`: combinational round-robin one-hot selector (`req`, `ptr` → `grant_next`), reusable elsewhere.

## Test plan
- NREQ=4, DATA_BITS=5, BITS=1, `req`=0001, `out_ready`=1:
  - `enc_start` one cycle after grant, with exactly 5 `take` pulses.
  - `out_id`=0 and 5 data words then ECC words, ending in `out_last`.
- `req`=1111 continuously: grants in order 0,1,2,3,0; `ptr` wraps after requester 3.
- After a frame from requester 2 with `req`=0101: next grant is requester 0, not 2.
- `out_ready` toggled 1,0,0,1 during RUN: `take` and `enc_ce` low for two cycles, no word lost or duplicated; the output codeword matches the golden encoder model.
- `reset` pulsed mid-RUN: the next cycle has `grant`=0 and `out_valid`=0, and no grant is issued until `enc_ready`=1. The next frame is bit-exact.
- `enc_ready` held 0 with `req`=0010: `grant` stays 0; the grant appears the cycle after `enc_ready` rises.
